// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master clocking blocks: default divider width and its type.
package spi_pkg;

   parameter int unsigned DefaultDividerWidth = 16;

   typedef logic [DefaultDividerWidth-1:0] divider_t;

endpackage

// File: rtl/spi_sclk_gen_if.sv
// Control and strobe bundle between the SPI controller (master) and the SCLK generator (slave).
interface spi_sclk_gen_if
   import spi_pkg::*;
#(
   parameter int unsigned DIVIDER_WIDTH = DefaultDividerWidth
);

   logic                     tip;
   logic                     go;
   logic                     last_clk;
   logic [DIVIDER_WIDTH-1:0] divider;
   logic                     sclk_out;
   logic                     cpol_0;
   logic                     cpol_1;

   modport master (
      output tip,
      output go,
      output last_clk,
      output divider,
      input  sclk_out,
      input  cpol_0,
      input  cpol_1
   );

   modport slave (
      input  tip,
      input  go,
      input  last_clk,
      input  divider,
      output sclk_out,
      output cpol_0,
      output cpol_1
   );

endinterface

// File: rtl/spi_sclk_divcnt.sv
// Reloading down-counter for the SCLK half-period; reloads while idle and exactly at zero.
module spi_sclk_divcnt
   import spi_pkg::*;
#(
   parameter int unsigned DIVIDER_WIDTH = DefaultDividerWidth
) (
   input  logic                     wb_clk,
   input  logic                     wb_rst,
   input  logic                     tip,
   input  logic [DIVIDER_WIDTH-1:0] reload_val,
   output logic                     cnt_zero,
   output logic                     cnt_one
);

   logic [DIVIDER_WIDTH-1:0] cnt_q, cnt_d;

   assign cnt_zero = (cnt_q == '0);
   assign cnt_one  = (cnt_q == DIVIDER_WIDTH'(1));

   always_comb begin
      cnt_d = cnt_q - DIVIDER_WIDTH'(1);
      if (!tip || cnt_zero) begin
         cnt_d = reload_val;
      end
   end

   always_ff @(posedge wb_clk) begin
      if (!wb_rst) begin
         cnt_q <= '1;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: sclk_out = wb_clk / (2*(divider+1)) during tip, plus edge strobes.
// Define SPI_CLKGEN_DIV_LATCH_EN to freeze the divider at transfer start (go && !tip).
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int unsigned DIVIDER_WIDTH = DefaultDividerWidth
) (
   input  logic          wb_clk,
   input  logic          wb_rst,
   spi_sclk_gen_if.slave bus
);

   logic [DIVIDER_WIDTH-1:0] div_eff;
   logic                     div_zero;
   logic                     cnt_zero;
   logic                     cnt_one;
   logic                     sclk_q, sclk_d;
   logic                     cpol_0_q, cpol_0_d;
   logic                     cpol_1_q, cpol_1_d;

`ifdef SPI_CLKGEN_DIV_LATCH_EN
   logic [DIVIDER_WIDTH-1:0] div_q;
   logic                     capture;

   assign capture = bus.go && !bus.tip;
   // Bypass on the capture cycle so the preload already sees the new value.
   assign div_eff = capture ? bus.divider : div_q;

   always_ff @(posedge wb_clk) begin
      if (!wb_rst) begin
         div_q <= '1;
      end else if (capture) begin
         div_q <= bus.divider;
      end
   end
`else
   assign div_eff = bus.divider;
`endif

   assign div_zero = (div_eff == '0);

   spi_sclk_divcnt #(
      .DIVIDER_WIDTH (DIVIDER_WIDTH)
   ) u_divcnt (
      .wb_clk     (wb_clk),
      .wb_rst     (wb_rst),
      .tip        (bus.tip),
      .reload_val (div_eff),
      .cnt_zero   (cnt_zero),
      .cnt_one    (cnt_one)
   );

   always_comb begin
      sclk_d = sclk_q;
      // Once last_clk is up the clock may still fall but never rises again.
      if (bus.tip && cnt_zero && (!bus.last_clk || sclk_q)) begin
         sclk_d = !sclk_q;
      end
   end

   always_comb begin
      cpol_0_d = (bus.tip && !sclk_q && cnt_one) ||
                 (div_zero && sclk_q) ||
                 (div_zero && bus.go && !bus.tip);
      cpol_1_d = (bus.tip && sclk_q && cnt_one) ||
                 (div_zero && !sclk_q && bus.tip);
   end

   always_ff @(posedge wb_clk) begin
      if (!wb_rst) begin
         sclk_q   <= 1'b0;
         cpol_0_q <= 1'b0;
         cpol_1_q <= 1'b0;
      end else begin
         sclk_q   <= sclk_d;
         cpol_0_q <= cpol_0_d;
         cpol_1_q <= cpol_1_d;
      end
   end

   assign bus.sclk_out = sclk_q;
   assign bus.cpol_0   = cpol_0_q;
   assign bus.cpol_1   = cpol_1_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Scoreboard bench for spi_sclk_gen: the driver queues hand-derived per-cycle outputs,
// a negedge monitor pops and compares them against sclk_out/cpol_0/cpol_1.
module tb_spi_sclk_gen;

   typedef struct {
      int    cyc;
      logic  s;
      logic  c0;
      logic  c1;
      string name;
   } exp_t;

   logic wb_clk = 1'b0;
   logic wb_rst;
   int   cyc = 0;
   int   applied = 0;
   int   miscompares = 0;
   exp_t sb[$];

   spi_sclk_gen_if #(.DIVIDER_WIDTH(16)) bus ();

   spi_sclk_gen #(
      .DIVIDER_WIDTH (16)
   ) dut (
      .wb_clk (wb_clk),
      .wb_rst (wb_rst),
      .bus    (bus)
   );

   always #5 wb_clk = ~wb_clk;

   always @(posedge wb_clk) cyc <= cyc + 1;

   // Monitor: outputs settled after posedge number e.cyc are checked on the following negedge.
   always @(negedge wb_clk) begin
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
         exp_t m;
         m = sb.pop_front();
         applied++;
         miscompares++;
         $display("FAIL %s: vector missed at cycle %0d (target %0d)", m.name, cyc, m.cyc);
      end
      if (sb.size() != 0 && sb[0].cyc == cyc) begin
         exp_t e;
         e = sb.pop_front();
         applied++;
         if ({bus.sclk_out, bus.cpol_0, bus.cpol_1} !== {e.s, e.c0, e.c1}) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got sclk_out=%b cpol_0=%b cpol_1=%b, want %b %b %b",
                     e.name, cyc, bus.sclk_out, bus.cpol_0, bus.cpol_1, e.s, e.c0, e.c1);
         end
      end
   end

   // Apply inputs for the next posedge and queue the outputs expected right after it.
   task automatic drive(input logic r, input logic t, input logic g, input logic l,
                        input logic [15:0] d, input logic es, input logic e0, input logic e1,
                        input string nm);
      exp_t e;
      @(posedge wb_clk);
      #2;
      wb_rst       = r;
      bus.tip      = t;
      bus.go       = g;
      bus.last_clk = l;
      bus.divider  = d;
      e.cyc  = cyc + 1;
      e.s    = es;
      e.c0   = e0;
      e.c1   = e1;
      e.name = nm;
      sb.push_back(e);
   endtask

   initial begin
      wb_rst       = 1'b0;
      bus.tip      = 1'b1;
      bus.go       = 1'b1;
      bus.last_clk = 1'b0;
      bus.divider  = 16'd4;

      // Reset held with tip=1
      repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, "reset");

      // Basic divide by 10: toggles every 5 edges, strobes one cycle ahead
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, "div4_preload");
      for (int k = 1; k <= 40; k++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd4, ((k / 5) % 2) == 1,
               ((k + 1) % 10) == 5, ((k + 1) % 10) == 0, $sformatf("div4_k%0d", k));
      end

      // last_clk raised while high: one fall at k=6, then low; cpol_0 still strobes on cnt_one
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd2, 1'b0, 1'b0, 1'b0, "last_preload");
      for (int k = 1; k <= 30; k++) begin
         logic s, c0, c1;
         if (k < 6) begin
            s  = ((k / 3) % 2) == 1;
            c0 = ((k + 1) % 6) == 3;
            c1 = ((k + 1) % 6) == 0;
         end else begin
            s  = 1'b0;
            c0 = (k % 3) == 2;
            c1 = 1'b0;
         end
         drive(1'b1, 1'b1, 1'b0, (k >= 4), 16'd2, s, c0, c1, $sformatf("last_k%0d", k));
      end

      // Fast mode: go with tip=0 strobes cpol_0, then toggle every cycle
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, "fast_idle");
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, "fast_go");
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, (k % 2) == 1, (k % 2) == 0, (k % 2) == 1,
               $sformatf("fast_k%0d", k));
      end

      // Idle: nothing moves; then the preloaded 7 gives first rise 8 cycles after tip
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd7, 1'b0, 1'b0, 1'b0, $sformatf("idle_k%0d", k));
      end
      for (int k = 1; k <= 16; k++) begin
         drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd7, (k >= 8 && k < 16), (k == 7), (k == 15),
               $sformatf("div7_k%0d", k));
      end

      // Divider changed 4 -> 9 mid-transfer at k=13
      drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd4, 1'b0, 1'b0, 1'b0, "chg_preload");
      for (int k = 1; k <= 40; k++) begin
         logic s, c0, c1;
         logic [15:0] d;
         d = (k >= 13) ? 16'd9 : 16'd4;
`ifdef SPI_CLKGEN_DIV_LATCH_EN
         s  = ((k / 5) % 2) == 1;
         c0 = ((k + 1) % 10) == 5;
         c1 = ((k + 1) % 10) == 0;
`else
         if (k < 13) begin
            s  = ((k / 5) % 2) == 1;
            c0 = ((k + 1) % 10) == 5;
            c1 = ((k + 1) % 10) == 0;
         end else begin
            s  = (k >= 15 && k < 25) || (k >= 35);
            c0 = (k + 1 == 15) || (k + 1 == 35);
            c1 = (k + 1 == 25);
         end
`endif
         drive(1'b1, 1'b1, 1'b0, 1'b0, d, s, c0, c1, $sformatf("chg_k%0d", k));
      end

      // Reset mid-transfer
      repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd9, 1'b0, 1'b0, 1'b0, "reset_mid");

      repeat (3) @(negedge wb_clk);
      #1;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d vectors never compared, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
